// File: rtl/ad_ip_jesd204_link_pkg.sv
`default_nettype none
// ============================================================================
// Module : ad_ip_jesd204_link_pkg
// Desc   : Shared state encoding and sizing helpers for the JESD204 SOF aligner.
// Rev    : 1.0 - initial release
// ============================================================================
package ad_ip_jesd204_link_pkg;

    localparam logic c_ST_SEARCH = 1'b0;
    localparam logic c_ST_LOCKED = 1'b1;

    typedef enum logic [0:0] {
        ST_SEARCH = c_ST_SEARCH,
        ST_LOCKED = c_ST_LOCKED
    } link_state_t;

    function automatic int lane_bits(input int octets);
        return 8 * octets;
    endfunction

    function automatic int beat_bits(input int lanes, input int octets);
        return lanes * lane_bits(octets);
    endfunction

    function automatic int offset_bits(input int octets);
        return (octets > 1) ? $clog2(octets) : 1;
    endfunction

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic int lowest_set_idx(input logic [63:0] vec);
        int idx;
        idx = 0;
        for (int i = 63; i >= 0; i--) begin
            if (vec[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ad_ip_jesd204_link_sof_align_if.sv
`default_nettype none
// ============================================================================
// Module : ad_ip_jesd204_link_sof_align_if
// Desc   : Beat stream and status bundle between link layer and SOF aligner.
// Rev    : 1.0 - initial release
// ============================================================================
interface ad_ip_jesd204_link_sof_align_if #(
    parameter int NUM_LANES       = 4,
    parameter int OCTETS_PER_BEAT = 8
);
    import ad_ip_jesd204_link_pkg::*;

    localparam int c_DATA_W = beat_bits(NUM_LANES, OCTETS_PER_BEAT);

    logic                       in_link_valid;
    logic [OCTETS_PER_BEAT-1:0] in_link_sof;
    logic [c_DATA_W-1:0]        in_link_data;
    logic                       out_link_valid;
    logic [OCTETS_PER_BEAT-1:0] out_link_sof;
    logic [c_DATA_W-1:0]        out_link_data;
    logic                       status_locked;
    logic                       status_align_err;

    modport master (
        output in_link_valid, in_link_sof, in_link_data,
        input  out_link_valid, out_link_sof, out_link_data,
        input  status_locked, status_align_err
    );

    modport slave (
        input  in_link_valid, in_link_sof, in_link_data,
        output out_link_valid, out_link_sof, out_link_data,
        output status_locked, status_align_err
    );

endinterface
`default_nettype wire

// File: rtl/ad_ip_jesd204_link_shifter.sv
`default_nettype none
// ============================================================================
// Module : ad_ip_jesd204_link_shifter
// Desc   : Registered 2*W -> W window select over {cur, prev} by unit offset k.
// Rev    : 1.0 - initial release
// ============================================================================
module ad_ip_jesd204_link_shifter #(
    parameter int UNITS     = 8,
    parameter int UNIT_BITS = 8,
    parameter int K_W       = 3
) (
    input  wire                         clk,
    input  wire                         rst,
    input  wire [UNITS*UNIT_BITS-1:0]   i_cur,
    input  wire [UNITS*UNIT_BITS-1:0]   i_prev,
    input  wire [K_W-1:0]               i_k,
    output logic [UNITS*UNIT_BITS-1:0]  o_data
);
    localparam int c_W = UNITS * UNIT_BITS;

    logic [c_W-1:0] w_window;
    logic [c_W-1:0] r_data;

    assign w_window = c_W'({i_cur, i_prev} >> (UNIT_BITS * int'(i_k)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
        end else begin
            r_data <= w_window;
        end
    end

    assign o_data = r_data;

endmodule
`default_nettype wire

// File: rtl/ad_ip_jesd204_link_sof_align.sv
`default_nettype none
// ============================================================================
// Module : ad_ip_jesd204_link_sof_align
// Desc   : Detects the SOF octet offset and realigns lane data/SOF to octet 0.
//          Optional SOF_ALIGN_ERR_CNT_EN adds a saturating status_err_cnt port.
// Rev    : 1.0 - initial release
// ============================================================================
module ad_ip_jesd204_link_sof_align
    import ad_ip_jesd204_link_pkg::*;
#(
    parameter int NUM_LANES       = 4,
    parameter int OCTETS_PER_BEAT = 8,
    parameter int SOF_STEP        = 4
) (
    input  wire                          link_clk,
    input  wire                          reset,
    ad_ip_jesd204_link_sof_align_if.slave link
`ifdef SOF_ALIGN_ERR_CNT_EN
    ,
    output logic [15:0]                  status_err_cnt
`endif
);
    localparam int c_LANE_W = lane_bits(OCTETS_PER_BEAT);
    localparam int c_DATA_W = beat_bits(NUM_LANES, OCTETS_PER_BEAT);
    localparam int c_K_W    = offset_bits(OCTETS_PER_BEAT);

    link_state_t                r_state;
    link_state_t                w_state_next;
    logic [c_K_W-1:0]           r_k;
    logic [c_K_W-1:0]           w_k_next;
    logic [c_K_W-1:0]           w_k_new;
    int                         w_k_new_idx;
    logic                       w_k_legal;
    logic                       w_sof_any;
    logic                       w_sof_at_k;
    logic [c_DATA_W-1:0]        r_prev_data;
    logic [OCTETS_PER_BEAT-1:0] r_prev_sof;
    logic                       r_out_valid;
    logic                       w_out_valid_next;
    logic                       r_align_err;
    logic                       w_align_err;

    assign w_k_new_idx = lowest_set_idx(64'(link.in_link_sof));
    assign w_k_new     = c_K_W'(w_k_new_idx);
    assign w_k_legal   = (w_k_new_idx % SOF_STEP) == 0;
    assign w_sof_any   = |link.in_link_sof;
    assign w_sof_at_k  = link.in_link_sof[r_k];

    always_comb begin
        w_state_next     = r_state;
        w_k_next         = r_k;
        w_align_err      = 1'b0;
        w_out_valid_next = 1'b0;
        if (!link.in_link_valid) begin
            w_state_next = ST_SEARCH;
        end else begin
            case (r_state)
                ST_SEARCH: begin
                    if (w_sof_any) begin
                        if (w_k_legal) begin
                            w_k_next     = w_k_new;
                            w_state_next = ST_LOCKED;
                        end else begin
                            w_align_err = 1'b1;
                        end
                    end
                end
                ST_LOCKED: begin
                    w_out_valid_next = 1'b1;
                    // The beat straddling an offset change mixes two phases; drop it.
                    if (w_sof_any && !w_sof_at_k) begin
                        w_align_err      = 1'b1;
                        w_out_valid_next = 1'b0;
                        if (w_k_legal) begin
                            w_k_next = w_k_new;
                        end else begin
                            w_state_next = ST_SEARCH;
                        end
                    end
                end
                default: w_state_next = ST_SEARCH;
            endcase
        end
    end

    always_ff @(posedge link_clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_SEARCH;
            r_k         <= '0;
            r_prev_data <= '0;
            r_prev_sof  <= '0;
            r_out_valid <= 1'b0;
            r_align_err <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_k         <= w_k_next;
            r_out_valid <= w_out_valid_next;
            r_align_err <= w_align_err;
            if (link.in_link_valid) begin
                r_prev_data <= link.in_link_data;
                r_prev_sof  <= link.in_link_sof;
            end else begin
                r_prev_data <= '0;
                r_prev_sof  <= '0;
            end
        end
    end

    generate
        for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
            ad_ip_jesd204_link_shifter #(
                .UNITS     (OCTETS_PER_BEAT),
                .UNIT_BITS (8),
                .K_W       (c_K_W)
            ) u_data_shift (
                .clk    (link_clk),
                .rst    (reset),
                .i_cur  (link.in_link_data[l*c_LANE_W +: c_LANE_W]),
                .i_prev (r_prev_data[l*c_LANE_W +: c_LANE_W]),
                .i_k    (r_k),
                .o_data (link.out_link_data[l*c_LANE_W +: c_LANE_W])
            );
        end
    endgenerate

    ad_ip_jesd204_link_shifter #(
        .UNITS     (OCTETS_PER_BEAT),
        .UNIT_BITS (1),
        .K_W       (c_K_W)
    ) u_sof_shift (
        .clk    (link_clk),
        .rst    (reset),
        .i_cur  (link.in_link_sof),
        .i_prev (r_prev_sof),
        .i_k    (r_k),
        .o_data (link.out_link_sof)
    );

    assign link.out_link_valid   = r_out_valid;
    assign link.status_locked    = (r_state == ST_LOCKED);
    assign link.status_align_err = r_align_err;

`ifdef SOF_ALIGN_ERR_CNT_EN
    logic [15:0] r_err_cnt;

    always_ff @(posedge link_clk or posedge reset) begin
        if (reset) begin
            r_err_cnt <= '0;
        end else if (w_align_err && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign status_err_cnt = r_err_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ad_ip_jesd204_link_sof_align.sv
`default_nettype none
// ============================================================================
// Module : tb_ad_ip_jesd204_link_sof_align
// Desc   : Directed table-driven bench for the JESD204 SOF aligner.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_ad_ip_jesd204_link_sof_align;

    localparam int c_LANES  = 4;
    localparam int c_OCT    = 8;
    localparam int c_STEP   = 4;
    localparam int c_DATA_W = c_LANES * 8 * c_OCT;

    localparam logic [63:0] c_A = 64'h0807060504030201;
    localparam logic [63:0] c_B = 64'h100F0E0D0C0B0A09;
    localparam logic [63:0] c_C = 64'h1817161514131211;
    localparam logic [63:0] c_D = 64'h201F1E1D1C1B1A19;
    localparam logic [63:0] c_E = 64'h2827262524232221;
    localparam logic [63:0] c_F = 64'h302F2E2D2C2B2A29;

    typedef struct {
        logic        v;
        logic [7:0]  sof;
        logic [63:0] d;
        logic        ev;
        logic [7:0]  esof;
        logic [63:0] ed;
        logic        elock;
        logic        eerr;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;
    vec_t tbl [22];

    always #5 clk = ~clk;

    ad_ip_jesd204_link_sof_align_if #(
        .NUM_LANES       (c_LANES),
        .OCTETS_PER_BEAT (c_OCT)
    ) link_if ();

`ifdef SOF_ALIGN_ERR_CNT_EN
    logic [15:0] err_cnt;
`endif

    ad_ip_jesd204_link_sof_align #(
        .NUM_LANES       (c_LANES),
        .OCTETS_PER_BEAT (c_OCT),
        .SOF_STEP        (c_STEP)
    ) dut (
        .link_clk (clk),
        .reset    (rst),
        .link     (link_if)
`ifdef SOF_ALIGN_ERR_CNT_EN
        ,
        .status_err_cnt (err_cnt)
`endif
    );

    // Each lane carries lane0 XOR a per-lane octet constant, which survives octet shifts.
    function automatic logic [c_DATA_W-1:0] expand(input logic [63:0] l0);
        logic [c_DATA_W-1:0] d;
        logic [7:0]          m;
        d = '0;
        for (int l = 0; l < c_LANES; l++) begin
            m = 8'(l * 64);
            d[l*64 +: 64] = l0 ^ {8{m}};
        end
        return d;
    endfunction

    function automatic vec_t mk(input logic v, input logic [7:0] sof, input logic [63:0] d,
                                input logic ev, input logic [7:0] esof, input logic [63:0] ed,
                                input logic elock, input logic eerr);
        vec_t r;
        r.v = v; r.sof = sof; r.d = d;
        r.ev = ev; r.esof = esof; r.ed = ed;
        r.elock = elock; r.eerr = eerr;
        return r;
    endfunction

    task automatic check(input string name, input logic [c_DATA_W-1:0] act,
                         input logic [c_DATA_W-1:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] sof, input logic [63:0] l0);
        link_if.in_link_valid = v;
        link_if.in_link_sof   = sof;
        link_if.in_link_data  = v ? expand(l0) : '0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        link_if.in_link_valid = 1'b0;
        link_if.in_link_sof   = '0;
        link_if.in_link_data  = '0;

        tbl[0]  = mk(1'b1, 8'h00, c_A, 1'b0, 8'h00, 64'h0, 1'b0, 1'b0);
        tbl[1]  = mk(1'b1, 8'h01, c_B, 1'b0, 8'h00, 64'h0, 1'b1, 1'b0);
        tbl[2]  = mk(1'b1, 8'h00, c_C, 1'b1, 8'h01, c_B,   1'b1, 1'b0);
        tbl[3]  = mk(1'b1, 8'h00, c_D, 1'b1, 8'h00, c_C,   1'b1, 1'b0);
        tbl[4]  = mk(1'b1, 8'h00, c_E, 1'b1, 8'h00, c_D,   1'b1, 1'b0);
        tbl[5]  = mk(1'b1, 8'h01, c_F, 1'b1, 8'h00, c_E,   1'b1, 1'b0);
        tbl[6]  = mk(1'b1, 8'h00, c_A, 1'b1, 8'h01, c_F,   1'b1, 1'b0);
        tbl[7]  = mk(1'b1, 8'h10, c_B, 1'b0, 8'h00, 64'h0, 1'b1, 1'b1);
        tbl[8]  = mk(1'b1, 8'h00, c_C, 1'b1, 8'h01, 64'h14131211100F0E0D, 1'b1, 1'b0);
        tbl[9]  = mk(1'b1, 8'h10, c_D, 1'b1, 8'h00, 64'h1C1B1A1918171615, 1'b1, 1'b0);
        tbl[10] = mk(1'b1, 8'h10, c_A, 1'b1, 8'h01, 64'h04030201201F1E1D, 1'b1, 1'b0);
        tbl[11] = mk(1'b1, 8'h00, c_B, 1'b1, 8'h01, 64'h0C0B0A0908070605, 1'b1, 1'b0);
        tbl[12] = mk(1'b1, 8'h02, c_C, 1'b0, 8'h00, 64'h0, 1'b0, 1'b1);
        tbl[13] = mk(1'b1, 8'h00, c_D, 1'b0, 8'h00, 64'h0, 1'b0, 1'b0);
        tbl[14] = mk(1'b1, 8'h02, c_E, 1'b0, 8'h00, 64'h0, 1'b0, 1'b1);
        tbl[15] = mk(1'b1, 8'h06, c_F, 1'b0, 8'h00, 64'h0, 1'b0, 1'b1);
        tbl[16] = mk(1'b1, 8'h30, c_A, 1'b0, 8'h00, 64'h0, 1'b1, 1'b0);
        tbl[17] = mk(1'b1, 8'h00, c_B, 1'b1, 8'h03, 64'h0C0B0A0908070605, 1'b1, 1'b0);
        tbl[18] = mk(1'b0, 8'h00, 64'h0, 1'b0, 8'h00, 64'h0, 1'b0, 1'b0);
        tbl[19] = mk(1'b1, 8'h00, c_C, 1'b0, 8'h00, 64'h0, 1'b0, 1'b0);
        tbl[20] = mk(1'b1, 8'h01, c_D, 1'b0, 8'h00, 64'h0, 1'b1, 1'b0);
        tbl[21] = mk(1'b1, 8'h00, c_E, 1'b1, 8'h01, c_D,   1'b1, 1'b0);

        // Reset state
        #1;
        check("reset out_valid", c_DATA_W'(link_if.out_link_valid), '0);
        check("reset out_sof",   c_DATA_W'(link_if.out_link_sof), '0);
        check("reset out_data",  link_if.out_link_data, '0);
        check("reset locked",    c_DATA_W'(link_if.status_locked), '0);
        check("reset align_err", c_DATA_W'(link_if.status_align_err), '0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 22; i++) begin
            drive(tbl[i].v, tbl[i].sof, tbl[i].d);
            check($sformatf("row%0d out_valid", i), c_DATA_W'(link_if.out_link_valid), c_DATA_W'(tbl[i].ev));
            check($sformatf("row%0d locked", i), c_DATA_W'(link_if.status_locked), c_DATA_W'(tbl[i].elock));
            check($sformatf("row%0d align_err", i), c_DATA_W'(link_if.status_align_err), c_DATA_W'(tbl[i].eerr));
            if (tbl[i].ev) begin
                check($sformatf("row%0d out_sof", i), c_DATA_W'(link_if.out_link_sof), c_DATA_W'(tbl[i].esof));
                check($sformatf("row%0d out_data", i), link_if.out_link_data, expand(tbl[i].ed));
            end
        end
`ifdef SOF_ALIGN_ERR_CNT_EN
        check("err_cnt after table", c_DATA_W'(err_cnt), c_DATA_W'(16'd4));
`endif

        // Relock to k=4, then assert reset mid-cycle while streaming
        drive(1'b1, 8'h10, c_F);
        drive(1'b1, 8'h00, c_A);
        check("pre-reset out_valid", c_DATA_W'(link_if.out_link_valid), c_DATA_W'(1'b1));
        check("pre-reset out_data", link_if.out_link_data, expand(64'h04030201302F2E2D));
        #2;
        rst = 1'b1;
        #1;
        check("mid reset out_valid", c_DATA_W'(link_if.out_link_valid), '0);
        check("mid reset out_sof",   c_DATA_W'(link_if.out_link_sof), '0);
        check("mid reset out_data",  link_if.out_link_data, '0);
        check("mid reset locked",    c_DATA_W'(link_if.status_locked), '0);
        check("mid reset align_err", c_DATA_W'(link_if.status_align_err), '0);
`ifdef SOF_ALIGN_ERR_CNT_EN
        check("mid reset err_cnt",   c_DATA_W'(err_cnt), '0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'h00, c_C);
            check($sformatf("post-reset%0d out_valid", i), c_DATA_W'(link_if.out_link_valid), '0);
            check($sformatf("post-reset%0d locked", i), c_DATA_W'(link_if.status_locked), '0);
        end
        drive(1'b1, 8'h01, c_B);
        check("relock locked", c_DATA_W'(link_if.status_locked), c_DATA_W'(1'b1));
        drive(1'b1, 8'h00, c_C);
        check("relock out_valid", c_DATA_W'(link_if.out_link_valid), c_DATA_W'(1'b1));
        check("relock out_data", link_if.out_link_data, expand(c_B));
        check("relock out_sof", c_DATA_W'(link_if.out_link_sof), c_DATA_W'(8'h01));

        // Illegal offset while searching
        drive(1'b0, 8'h00, 64'h0);
        drive(1'b1, 8'h02, c_D);
        check("illegal align_err", c_DATA_W'(link_if.status_align_err), c_DATA_W'(1'b1));
        check("illegal locked", c_DATA_W'(link_if.status_locked), '0);
`ifdef SOF_ALIGN_ERR_CNT_EN
        check("illegal err_cnt", c_DATA_W'(err_cnt), c_DATA_W'(16'd1));
`endif
        drive(1'b1, 8'h00, c_E);
        check("err pulse width", c_DATA_W'(link_if.status_align_err), '0);

`ifdef SOF_ALIGN_ERR_CNT_EN
        for (int i = 0; i < 70000; i++) begin
            drive(1'b1, 8'h02, c_A);
        end
        check("err_cnt saturate", c_DATA_W'(err_cnt), c_DATA_W'(16'hFFFF));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
